// File: rtl/result_streamer.sv
// Drains a contiguous BRAM_R region into a valid/ready stream through a 2-deep skid FIFO.
// State | meaning:  IDLE | waiting for start;  RUN | reading and streaming words;  DONE | one-cycle completion pulse.
module result_streamer #(
    parameter int PE_COUNT   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [ADDR_WIDTH:0]              count,
    output logic                             busy,
    output logic                             done,
    output logic                             bram_r_en,
    output logic [ADDR_WIDTH-1:0]            bram_r_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0]   bram_r_data,
    output logic [PE_COUNT*DATA_WIDTH-1:0]   m_data,
    output logic                             m_valid,
    output logic                             m_last,
    input  logic                             m_ready
);

    localparam int W = PE_COUNT * DATA_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_WIDTH:0] L_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] L_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH:0]   r_rd_left;
    logic                  r_infl;
    logic                  r_infl_last;
    logic [1:0]            r_occ;
    logic [W-1:0]          r_head_data;
    logic                  r_head_last;
    logic [W-1:0]          r_tail_data;
    logic                  r_tail_last;

    logic [2:0]            w_fill;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_rd_en;
    logic                  w_rd_last;

    // Outputs are gated by rst so they read zero for the whole reset window,
    // including the first cycle before the registers have been cleared.
    assign busy        = (r_state == S_RUN) & ~rst;
    assign done        = (r_state == S_DONE) & ~rst;
    assign m_valid     = (r_occ != 2'd0) & ~rst;
    assign m_last      = r_head_last & m_valid;
    assign m_data      = rst ? '0 : r_head_data;

    assign w_pop       = m_valid & m_ready;
    assign w_push      = r_infl;
    assign w_fill      = {1'b0, r_occ} + {2'b00, r_infl};
    assign w_rd_last   = (r_rd_left == L_ONE);

    // A slot freed by this cycle's handshake may be claimed by a new read.
    assign w_rd_en     = ~rst & (r_state == S_RUN) & (r_rd_left != L_ZERO) &
                         ((w_fill < 3'd2) | ((w_fill == 3'd2) & w_pop));

    assign bram_r_en   = w_rd_en;
    assign bram_r_addr = w_rd_en ? r_rd_addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rd_addr   <= '0;
            r_rd_left   <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_occ       <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (count == L_ZERO) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state   <= S_RUN;
                            r_rd_addr <= base_addr;
                            r_rd_left <= count;
                        end
                    end
                end
                S_RUN: begin
                    if (w_rd_en) begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                        r_rd_left <= r_rd_left - L_ONE;
                    end
                    if (w_pop && r_head_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            r_infl      <= w_rd_en;
            r_infl_last <= w_rd_en & w_rd_last;

            // Head always holds the oldest word; the tail only fills while head is occupied.
            if (w_pop) begin
                r_head_data <= r_tail_data;
                r_head_last <= r_tail_last;
                if (w_push && (r_occ == 2'd1)) begin
                    r_head_data <= bram_r_data;
                    r_head_last <= r_infl_last;
                end else if (w_push) begin
                    r_tail_data <= bram_r_data;
                    r_tail_last <= r_infl_last;
                end
            end else if (w_push) begin
                if (r_occ == 2'd0) begin
                    r_head_data <= bram_r_data;
                    r_head_last <= r_infl_last;
                end else begin
                    r_tail_data <= bram_r_data;
                    r_tail_last <= r_infl_last;
                end
            end

            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: exact timing, random backpressure, address wrap, empty drain, abort and ignored start.
module tb_result_streamer;

    localparam int PE = 4;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int W  = PE * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          bram_r_en;
    logic [AW-1:0] bram_r_addr;
    logic [W-1:0]  bram_r_data;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    int n_assert = 0;
    int n_fail   = 0;

    result_streamer #(.PE_COUNT(PE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .bram_r_en(bram_r_en), .bram_r_addr(bram_r_addr),
        .bram_r_data(bram_r_data), .m_data(m_data), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input logic [AW-1:0] a);
        logic [W-1:0] w;
        w = '0;
        for (int l = 0; l < PE; l++) w[l*DW +: DW] = {4'hA, 4'(l), 14'd0, a};
        return w;
    endfunction

    // BRAM_R model: one-cycle read latency; garbage when not read so stray captures show up.
    always @(posedge clk) begin
        if (bram_r_en) bram_r_data <= word(bram_r_addr);
        else           bram_r_data <= {PE{32'hDEADBEEF}};
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  W'(busy),        '0);
        chk({tag, "_done"},  W'(done),        '0);
        chk({tag, "_en"},    W'(bram_r_en),   '0);
        chk({tag, "_addr"},  W'(bram_r_addr), '0);
        chk({tag, "_valid"}, W'(m_valid),     '0);
        chk({tag, "_last"},  W'(m_last),      '0);
        chk({tag, "_data"},  m_data,          '0);
    endtask

    // Runs one drain from a start in the next cycle, checking order, addresses, stall stability and buffering bound.
    task automatic drain(input logic [AW-1:0] base, input int n, input bit rnd, input bit inject);
        int            issued = 0;
        int            acc = 0;
        int            cyc = 0;
        bit            got_done = 0;
        bit            prev_stall = 0;
        logic [W-1:0]  prev_d = '0;
        logic          prev_l = 1'b0;
        logic [AW-1:0] ea;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1; base_addr = base; count = (AW+1)'(n); m_ready = 1'b1;
        @(negedge clk);
        chk("start_cycle_idle_busy", W'(busy), '0);
        chk("start_cycle_idle_en", W'(bram_r_en), '0);
        chk("start_cycle_idle_valid", W'(m_valid), '0);
        while (!got_done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (inject && cyc == 3) begin
                start = 1'b1; base_addr = 10'd500; count = 11'd2;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            chk("buffered_plus_inflight_le2", W'(issued - acc <= 2), W'(1'b1));
            if (bram_r_en) begin
                ea = base + AW'(issued);
                chk("rd_addr", W'(bram_r_addr), W'(ea));
                issued++;
            end else begin
                chk("rd_addr_idle_zero", W'(bram_r_addr), '0);
            end
            if (prev_stall) begin
                chk("stall_valid", W'(m_valid), W'(1'b1));
                chk("stall_data", m_data, prev_d);
                chk("stall_last", W'(m_last), W'(prev_l));
            end
            if (m_valid && m_ready) begin
                ea = base + AW'(acc);
                chk("word_data", m_data, word(ea));
                chk("word_last", W'(m_last), W'(acc == n - 1));
                acc++;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (done) begin
                got_done = 1;
                chk("done_words_accepted", W'(acc), W'(n));
                chk("done_reads_issued", W'(issued), W'(n));
            end
        end
        chk("drain_done_seen", W'(got_done), W'(1'b1));
        @(posedge clk); #1;
        start = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("after_done_done_low", W'(done), '0);
        chk("after_done_busy_low", W'(busy), '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Exact timing: base 0, count 4, ready held; start accepted right after reset release
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b1; base_addr = 10'd0; count = 11'd4;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            chk("t1_en", W'(bram_r_en), W'(c >= 1 && c <= 4));
            chk("t1_addr", W'(bram_r_addr), (c >= 1 && c <= 4) ? W'(c - 1) : '0);
            chk("t1_valid", W'(m_valid), W'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk("t1_data", m_data, word(AW'(c - 3)));
            chk("t1_last", W'(m_last), W'(c == 6));
            chk("t1_busy", W'(busy), W'(c >= 1 && c <= 6));
            chk("t1_done", W'(done), W'(c == 7));
        end

        // Random backpressure
        drain(10'd100, 6, 1'b1, 1'b0);

        // Address wrap at the top of the array
        drain(10'd1022, 4, 1'b0, 1'b0);

        // Empty drain
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd7; count = 11'd0;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                start = 1'b0;
            end
            @(negedge clk);
            chk("c0_done", W'(done), W'(c == 1));
            chk("c0_en", W'(bram_r_en), '0);
            chk("c0_valid", W'(m_valid), '0);
            chk("c0_busy", W'(busy), '0);
        end

        // Abort after two words, then restart immediately
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'd0; count = 11'd8; m_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("abort_pre_valid", W'(m_valid), W'(1'b1));
        chk("abort_pre_data", m_data, word(10'd1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("abort_rst");
        drain(10'd5, 1, 1'b0, 1'b0);

        // Start pulsed mid-drain must be ignored
        drain(10'd200, 5, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
